// File: rtl/req_gnt_tracker_pkg.sv
// Shared types and sizing helpers for the request/grant tracker.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/req_gnt_tracker_fifo.sv
// In-order ID queue for outstanding requests; a push while full is taken only when the same edge pops.
module sync_fifo
  import req_gnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/req_gnt_tracker.sv
// Turns req rising edges into ID-tagged requests and issues in-order single-cycle grants after a programmable latency.
module req_gnt_tracker
  import req_gnt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LAT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [LAT_W-1:0]         lat,
  output logic [ID_W-1:0]          req_id,
  output logic                     gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic [cnt_w(DEPTH)-1:0]  outstanding,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  logic             req_q, req_d;
  logic [ID_W-1:0]  id_cnt_q, id_cnt_d;
  logic [ID_W-1:0]  req_id_q, req_id_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;

  logic             rise;
  logic             pop;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  fifo_dout;

  // The head is popped while the grant is visible, so a full queue can still accept on that edge.
  assign rise   = req & ~req_q;
  assign pop    = (state_q == GRANT);
  assign accept = rise & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (id_cnt_q),
    .dout  (fifo_dout),
    .count (outstanding),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    req_d    = req;
    id_cnt_d = id_cnt_q;
    req_id_d = req_id_q;
    ovf_d    = ovf_q;
    if (accept) begin
      id_cnt_d = id_cnt_q + ID_W'(1);
      req_id_d = id_cnt_q;
    end else if (rise) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      id_cnt_q <= '0;
      req_id_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      req_q    <= req_d;
      id_cnt_q <= id_cnt_d;
      req_id_q <= req_id_d;
      ovf_q    <= ovf_d;
    end
  end

  // gnt rises on the same edge the FSM enters GRANT, so it is high exactly while in GRANT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = 1'b0;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WAIT;
          cnt_d   = (lat == '0) ? LAT_W'(1) : lat;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d  = GRANT;
          gnt_d    = 1'b1;
          gnt_id_d = fifo_dout;
        end
      end
      GRANT:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign req_id = req_id_q;
  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign full   = fifo_full;
  assign empty  = fifo_empty;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_req_gnt_tracker.sv
// Directed and random checks of req_gnt_tracker against a queue-and-schedule reference model.
module tb_req_gnt_tracker;
  import req_gnt_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int LAT_W = 3;
  localparam int CW    = cnt_w(DEPTH);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req = 1'b0;
  logic [LAT_W-1:0] lat = '0;
  logic [ID_W-1:0]  req_id;
  logic             gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [CW-1:0]    outstanding;
  logic             full;
  logic             empty;
  logic             ovf;

  always #5 clk = ~clk;

  req_gnt_tracker #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .LAT_W (LAT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lat         (lat),
    .req_id      (req_id),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .outstanding (outstanding),
    .full        (full),
    .empty       (empty),
    .ovf         (ovf)
  );

  int  n_assert = 0;
  int  n_fail   = 0;
  time t_gnt_rise = 0;

  always @(posedge gnt) t_gnt_rise = $time;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Accepted IDs wait in exp_q; the head is given a grant edge when the
  // granter is free, computed as decision edge + max(lat,1).
  logic [ID_W-1:0] exp_q[$];
  int              push_edge_q[$];
  int              edge_n;
  bit              sched;
  int              g_edge;
  int              next_free;
  logic            m_prev_req;
  logic [ID_W-1:0] m_id, m_req_id, m_gnt_id;
  logic            m_gnt, m_ovf;

  // Grants observed in the current scenario.
  int              gnt_cnt;
  logic [ID_W-1:0] gnt_ids[$];
  int              gnt_edges[$];
  int              rise_edges[$];

  task automatic model_reset();
    exp_q.delete();
    push_edge_q.delete();
    sched      = 1'b0;
    g_edge     = 0;
    next_free  = 0;
    m_prev_req = 1'b0;
    m_id       = '0;
    m_req_id   = '0;
    m_gnt_id   = '0;
    m_gnt      = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_edge();
    bit pop_now, rise, full_pre, acc;
    edge_n++;
    pop_now    = sched && (g_edge + 1 == edge_n);
    rise       = req && !m_prev_req;
    m_prev_req = req;
    full_pre   = (exp_q.size() == DEPTH);
    acc        = rise && (!full_pre || pop_now);
    if (rise && !acc) m_ovf = 1'b1;
    if (pop_now) begin
      void'(exp_q.pop_front());
      void'(push_edge_q.pop_front());
      sched     = 1'b0;
      next_free = edge_n + 2;
    end
    if (acc) begin
      exp_q.push_back(m_id);
      push_edge_q.push_back(edge_n);
      m_req_id = m_id;
      m_id     = m_id + 1'b1;
    end
    if (!sched && exp_q.size() > 0 && edge_n >= next_free && push_edge_q[0] < edge_n) begin
      sched  = 1'b1;
      g_edge = edge_n + ((lat == '0) ? 1 : int'(lat));
    end
    m_gnt = sched && (g_edge == edge_n);
    if (m_gnt) m_gnt_id = exp_q[0];
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("gnt",         32'(gnt),         32'(m_gnt));
    chk("gnt_id",      32'(gnt_id),      32'(m_gnt_id));
    chk("req_id",      32'(req_id),      32'(m_req_id));
    chk("outstanding", 32'(outstanding), 32'(exp_q.size()));
    chk("full",        32'(full),        32'(exp_q.size() == DEPTH));
    chk("empty",       32'(empty),       32'(exp_q.size() == 0));
    chk("ovf",         32'(ovf),         32'(m_ovf));
    if (gnt === 1'b1) begin
      gnt_cnt++;
      gnt_ids.push_back(gnt_id);
      gnt_edges.push_back(edge_n);
    end
  endtask

  function automatic logic [31:0] get_id(input int k);
    if (k < gnt_ids.size()) return 32'(gnt_ids[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_edge(input int k);
    if (k < gnt_edges.size()) return 32'(gnt_edges[k]);
    return 32'hFFFF_FFFF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic [LAT_W-1:0] l);
    req = r;
    lat = l;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic [LAT_W-1:0] l);
    for (int i = 0; i < n; i++) cycle(1'b0, l);
  endtask

  // Asserts reset away from a clock edge, checks the async clear, holds it over one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gnt_cnt = 0;
    gnt_ids.delete();
    gnt_edges.delete();
    rise_edges.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    edge_n = 0;
    gnt_cnt = 0;
    model_reset();
    #2;
    do_reset();

    // Single request, lat=3: rise sampled at 15 ns, grant visible 55..65 ns.
    cycle(1'b1, 3'd3);
    idle(8, 3'd3);
    chk("s1_gnt_time", 32'(t_gnt_rise), 32'd55);
    chk("s1_gnt_cnt",  32'(gnt_cnt), 32'd1);
    chk("s1_gnt_id",   get_id(0), 32'd0);

    // Two requests three cycles apart, lat=4.
    do_reset();
    cycle(1'b1, 3'd4);
    idle(2, 3'd4);
    cycle(1'b1, 3'd4);
    idle(16, 3'd4);
    chk("s2_gnt_cnt", 32'(gnt_cnt), 32'd2);
    chk("s2_id0",     get_id(0), 32'd0);
    chk("s2_id1",     get_id(1), 32'd1);
    chk("s2_spacing", get_edge(1) - get_edge(0), 32'd7);

    // Level hold: five cycles high is one request.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'd2);
    idle(10, 3'd2);
    chk("s3_gnt_cnt", 32'(gnt_cnt), 32'd1);
    cycle(1'b1, 3'd2);
    cycle(1'b0, 3'd2);
    chk("s3_next_id", 32'(req_id), 32'd1);
    idle(8, 3'd2);

    // Overflow: six rises two cycles apart with lat=7; the fifth is dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 3'd7);
      cycle(1'b0, 3'd7);
    end
    idle(60, 3'd7);
    chk("s4_ovf",     32'(ovf), 32'd1);
    chk("s4_gnt_cnt", 32'(gnt_cnt), 32'd5);
    for (int i = 0; i < 5; i++) chk("s4_id_seq", get_id(i), 32'(i));

    // ID wrap with lat=0 (behaves as 1).
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rise_edges.push_back(edge_n + 1);
      cycle(1'b1, 3'd0);
      idle(6, 3'd0);
    end
    chk("s5_gnt_cnt", 32'(gnt_cnt), 32'd18);
    chk("s5_id17",    get_id(16), 32'd0);
    chk("s5_id18",    get_id(17), 32'd1);
    for (int i = 0; i < 18; i++)
      chk("s5_latency", get_edge(i) - 32'(rise_edges[i]), 32'd2);

    // Reset while the first of two queued requests is waiting.
    do_reset();
    cycle(1'b1, 3'd5);
    cycle(1'b0, 3'd5);
    cycle(1'b1, 3'd5);
    cycle(1'b0, 3'd5);
    cycle(1'b0, 3'd5);
    do_reset();
    chk("s6_gnt_cnt_after_rst", 32'(gnt_cnt), 32'd0);
    cycle(1'b1, 3'd3);
    cycle(1'b0, 3'd3);
    chk("s6_req_id", 32'(req_id), 32'd0);
    idle(8, 3'd3);
    chk("s6_gnt_cnt", 32'(gnt_cnt), 32'd1);
    chk("s6_gnt_id",  get_id(0), 32'd0);

    // Random req / lat traffic, including lat changes mid-wait and overflow.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), LAT_W'($urandom_range(0, 7)));
      if (i == 250) do_reset();
    end
    idle(40, 3'd1);
    chk("rand_drained", 32'(outstanding), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/req_gnt_tracker.md
Name: req_gnt_tracker

Overview:
- Grant-issuing stage that sits directly downstream of the req/gnt assertion bench's stimulus. It consumes level `req` pulses and produces single-cycle `gnt` pulses.
- Every rising edge of `req` becomes an outstanding request with a sequence ID, queued in order in a small FIFO.
- A service FSM grants queued requests strictly in order, after a programmable latency, and reports the ID of each grant.
- The ID pairing lets checkers match each grant to its own request instead of to any earlier request.

Parameters:
- DEPTH, 4: maximum outstanding requests (FIFO entries); power of two, ≥2.
- ID_W, 4: width of request/grant sequence ID; the ID counter wraps modulo 2^ID_W.
- LAT_W, 3: width of the `lat` latency input.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request level; each 0→1 transition sampled at posedge is one request.
- lat  input  LAT_W  wait cycles before grant; latched when the FSM enters WAIT; 0 is treated as 1.
- req_id  output  ID_W  ID assigned to the most recently accepted request.
- gnt  output  1  single-cycle grant pulse, registered.
- gnt_id  output  ID_W  ID of the granted request; valid while gnt=1, holds last value otherwise.
- outstanding  output  $clog2(DEPTH+1)  number of queued, ungranted requests.
- full  output  1  outstanding==DEPTH.
- empty  output  1  outstanding==0.
- ovf  output  1  sticky: a request rise was dropped because the queue was full.

Behaviour:
- Reset (async assert, sync release) clears:
  - req_q=0, id_cnt=0, req_id=0
  - FIFO pointers=0, outstanding=0, full=0, empty=1
  - gnt=0, gnt_id=0, ovf=0
  - FSM=IDLE
- A reset mid-operation discards all queued requests with no grant issued.
- Rise detect: rise = req & ~req_q, with req_q registered every cycle.
  - Holding req high for several cycles counts as one request.
  - req already high when reset is released counts as a rise on the first edge.
- Accept: on an edge with rise=1 and (!full or pop on the same edge):
  - push id_cnt;
  - req_id<=id_cnt;
  - id_cnt<=id_cnt+1 (wraps).
- Drop: rise while full without a same-edge pop → request dropped, ovf<=1, id_cnt unchanged. ovf clears only on reset.
- FSM states: IDLE, WAIT, GRANT, GAP.
  - IDLE: if !empty → WAIT, cnt<=max(lat,1).
  - WAIT: cnt<=cnt-1; if cnt==1 → GRANT.
  - GRANT: gnt=1, gnt_id=head ID, pop the head; → GAP.
  - GAP: gnt=0; → IDLE.
- The GAP state guarantees gnt is low for at least one cycle between grants, so every grant is a distinct 0→1 transition.
- The FSM sees a pushed entry on the edge after the push.
- Latency: with the FIFO empty and the FSM idle, a rise sampled at edge E0 gives gnt=1 for exactly the cycle after edge E0+lat+1.
- Back-to-back queued requests: the next grant follows lat+3 cycles after the previous grant (GAP, IDLE, then lat WAIT cycles).
- Simultaneous push and pop: outstanding is unchanged; a push while full is permitted only when the same edge pops.
- Ordering: grants occur in acceptance order; gnt_id sequence = accepted ID sequence modulo 2^ID_W.
- A lat change during WAIT has no effect until the next WAIT entry.

Decomposition:
- Package req_gnt_pkg holds:
  - state_e enum {IDLE, WAIT, GRANT, GAP};
  - localparam function cnt_w(depth) = $clog2(depth+1).
- One sub-module: sync_fifo (width ID_W, depth DEPTH) exposing push, pop, din, dout, count, full, empty. The top level holds rise detect, ID counter, FSM and ovf.

Test Plan:
- Single request, lat=3 (10 ns clock): req rise sampled at posedge 15 → gnt=1 from 55 to 65, gnt_id=0, req_id=0, then outstanding=0, empty=1.
- Two requests 3 cycles apart, lat=4 → two gnt pulses in order with gnt_id 0 then 1. The second grant comes ≥7 cycles after the first, with gnt low in between.
- Level hold: req high for 5 cycles, lat=2 → exactly one gnt, id_cnt advances by 1.
- Overflow, DEPTH=4, lat=7: 6 rises spaced 2 cycles apart → the 5th or 6th rise (whichever arrives while full) is dropped, ovf=1 and stays 1. Exactly 4 or 5 grants total, IDs contiguous from 0.
- Wrap and lat=0: with ID_W=4, 18 sequential requests at lat=0 → the 17th grant shows gnt_id=0 and the 18th shows gnt_id=1; each grant comes 2 cycles after its rise edge (lat treated as 1).
- Reset mid-WAIT: 2 requests queued, rst_n low for 1 cycle → immediately gnt=0, outstanding=0, ovf=0. The next request gets ID 0.
